// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle SLL/SRL/SRA, one bit position per clock.
module shift_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [4:0]       shamt,
    input  logic [WIDTH-1:0] operand,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             err
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    localparam logic [1:0] OP_SLL = 2'd0;
    localparam logic [1:0] OP_SRA = 2'd2;
    localparam logic [1:0] OP_ILL = 2'd3;

    state_t            state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [1:0]        op_q, op_d;
    logic [WIDTH-1:0]  work_q, work_d, result_q, result_d, shifted;
    logic              err_q, err_d, accept;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        work_d   = work_q;
        result_d = result_q;
        err_d    = err_q;
        accept   = start && !flush && state_q != SHIFT;
        shifted  = op_q == OP_SLL ? {work_q[WIDTH-2:0], 1'b0}
                                  : {op_q == OP_SRA && work_q[WIDTH-1], work_q[WIDTH-1:1]};
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (accept) begin
            work_d  = operand;
            cnt_d   = shamt;
            op_d    = op;
            err_d   = op == OP_ILL;
            // Illegal ops and zero shifts complete immediately with the operand.
            if (op == OP_ILL || shamt == '0) begin
                state_d  = DONE;
                result_d = operand;
            end else begin
                state_d = SHIFT;
            end
        end else if (state_q == SHIFT) begin
            work_d = shifted;
            cnt_d  = cnt_q - 5'd1;
            if (cnt_q == 5'd1) begin
                result_d = shifted;
                state_d  = DONE;
            end
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            work_q   <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            work_q   <= work_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    assign busy   = state_q == SHIFT;
    assign done   = state_q == DONE;
    assign result = result_q;
    assign err    = err_q;
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: directed plus random checks of shift_sequencer against an arithmetic model.
module tb_shift_sequencer;
    logic        clk = 0, rst_n = 0, start = 0, flush = 0;
    logic [1:0]  op = 0;
    logic [4:0]  shamt = 0;
    logic [31:0] operand = 0;
    logic        busy, done, err;
    logic [31:0] result;
    int          total = 0, bad = 0;
    logic [31:0] prev_res = 0;
    logic        prev_err = 0;

    shift_sequencer #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .shamt(shamt),
        .operand(operand), .flush(flush), .busy(busy), .done(done),
        .result(result), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] o, input logic [4:0] s, input logic [31:0] v);
        case (o)
            2'd0:    return v << s;
            2'd1:    return v >> s;
            2'd2:    return $signed(v) >>> s;
            default: return v;
        endcase
    endfunction

    // Drives start in the current cycle (cycle 0) and checks every following cycle.
    // Leaves the bench inside the done cycle so a following call starts back-to-back.
    task automatic run(input logic [1:0] o, input logic [4:0] s, input logic [31:0] v,
                       input int poke_c, input int flush_c);
        int dc, last;
        bit fl;
        dc   = (o == 2'd3 || s == 0) ? 1 : int'(s) + 1;
        fl   = flush_c > 0 && flush_c < dc;
        last = fl ? flush_c + 2 : dc;
        start = 1; op = o; shamt = s; operand = v;
        for (int c = 1; c <= last; c++) begin
            @(posedge clk); #1;
            chk("busy", {31'd0, busy}, {31'd0, o != 2'd3 && c <= int'(s) && (!fl || c <= flush_c)});
            chk("done", {31'd0, done}, {31'd0, !fl && c == dc});
            if (!fl && c == dc) begin
                chk("result", result, model(o, s, v));
                chk("err", {31'd0, err}, {31'd0, o == 2'd3});
            end else begin
                chk("result_hold", result, prev_res);
                chk("err_clear", {31'd0, err}, 32'd0);
            end
            start = (c == poke_c);
            if (start) begin
                op = 2'($urandom_range(0, 2)); shamt = 5'($urandom); operand = $urandom | 32'h1000;
            end
            flush = (c == flush_c);
        end
        start = 0; flush = 0;
        if (!fl) prev_res = model(o, s, v);
        prev_err = !fl && o == 2'd3;
    endtask

    task automatic idle(input int n);
        start = 0;
        repeat (n) begin
            @(posedge clk); #1;
            chk("idle_busy", {31'd0, busy}, 32'd0);
            chk("idle_done", {31'd0, done}, 32'd0);
            chk("idle_result", result, prev_res);
            chk("idle_err", {31'd0, err}, {31'd0, prev_err});
        end
    endtask

    initial begin
        #12;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1;
        run(2'd0, 5'd4, 32'h1, 0, 0);               idle(1);
        run(2'd2, 5'd31, 32'h8000_0000, 0, 0);      idle(1);
        run(2'd1, 5'd31, 32'h8000_0000, 0, 0);      idle(1);
        run(2'd0, 5'd0, 32'hDEAD_BEEF, 0, 0);       idle(1);
        run(2'd3, 5'd7, 32'h1234_5678, 0, 0);       idle(1);
        run(2'd0, 5'd8, 32'h1, 3, 0);
        run(2'd1, 5'd5, 32'hF0F0_F0F0, 0, 0);       idle(1);
        run(2'd1, 5'd10, 32'hABCD_0000, 0, 4);      idle(2);
        run(2'd2, 5'd3, 32'h8000_0010, 0, 0);
        // flush beats a start presented in the done cycle
        start = 1; flush = 1; op = 2'd0; shamt = 5'd5; operand = 32'h1;
        @(posedge clk); #1;
        start = 0; flush = 0;
        chk("flush_win_busy", {31'd0, busy}, 32'd0);
        chk("flush_win_done", {31'd0, done}, 32'd0);
        chk("flush_win_result", result, prev_res);
        idle(1);
        start = 1; op = 2'd0; shamt = 5'd20; operand = $urandom;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            start = 0;
        end
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        #1 rst_n = 0;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        chk("mid_rst_result", result, 32'd0);
        chk("mid_rst_err", {31'd0, err}, 32'd0);
        #1 rst_n = 1;
        prev_res = 0; prev_err = 0;
        idle(18);
        run(2'd0, 5'd1, 32'h3, 0, 0);               idle(1);
        for (int i = 0; i < 30; i++) begin
            run(2'($urandom_range(0, 3)), 5'($urandom), $urandom, 0, 0);
            if ($urandom_range(0, 1) == 1) idle(1);
        end
        idle(1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
